// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg: shared constants, group lookahead helpers and parameter legality check
package add_pipe_pkg;
  localparam int GRP_W = 4;
  function automatic logic grp_gen(input logic [GRP_W-1:0] g, input logic [GRP_W-1:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction
  function automatic logic grp_prop(input logic [GRP_W-1:0] p);
    return &p;
  endfunction
  function automatic logic params_ok(input int width, input int stages);
    return width >= GRP_W && width % GRP_W == 0 && stages >= 1 &&
           stages <= width / GRP_W && (width / GRP_W) % stages == 0;
  endfunction
endpackage

// File: rtl/cla_group.sv
// cla_group: 4-bit carry-lookahead slice producing sum plus group generate/propagate
module cla_group
  import add_pipe_pkg::*;
(
  input  logic [GRP_W-1:0] i_a,
  input  logic [GRP_W-1:0] i_b,
  input  logic             i_c,
  output logic [GRP_W-1:0] o_sum,
  output logic             o_g,
  output logic             o_p
);
  logic [GRP_W-1:0] w_g, w_p, w_c;
  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;
  assign w_c = {w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]) | (w_p[2] & w_p[1] & w_p[0] & i_c),
                w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c),
                w_g[0] | (w_p[0] & i_c),
                i_c};
  assign o_sum = w_p ^ w_c;
  assign o_g = grp_gen(w_g, w_p);
  assign o_p = grp_prop(w_p);
endmodule

// File: rtl/add_pipe.sv
// add_pipe: pipelined CLA adder/subtractor with valid/ready handshake.
// Define ADD_PIPE_SAT_EN to saturate sum on signed overflow.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int GPS = WIDTH / GRP_W / STAGES;
  localparam int SW  = GPS * GRP_W;
  logic w_adv;
  if (!params_ok(WIDTH, STAGES)) begin : g_bad
    $error("add_pipe: WIDTH must be a multiple of 4 and STAGES must divide WIDTH/4");
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SW;
    localparam int HI = LO + SW;
    logic [WIDTH-1:LO] w_a, w_b;
    logic [HI-1:0] w_s, w_s_nx, r_s;
    logic [SW-1:0] w_sg;
    logic [GPS-1:0] w_g, w_p;
    logic [GPS:0] w_c;
    logic w_ci, w_vi, r_c, r_v;
    if (k == 0) begin : g_in
      assign w_a = a;
      assign w_b = sub ? ~b : b;
      assign w_ci = sub | cin;
      assign w_vi = in_valid;
      assign w_s = w_sg;
    end else begin : g_in
      assign w_a = g_st[k-1].g_fwd.r_a;
      assign w_b = g_st[k-1].g_fwd.r_b;
      assign w_ci = g_st[k-1].r_c;
      assign w_vi = g_st[k-1].r_v;
      assign w_s = {w_sg, g_st[k-1].r_s};
    end
    for (genvar i = 0; i < GPS; i++) begin : g_grp
      cla_group u_grp (
        .i_a  (w_a[LO+i*GRP_W +: GRP_W]),
        .i_b  (w_b[LO+i*GRP_W +: GRP_W]),
        .i_c  (w_c[i]),
        .o_sum(w_sg[i*GRP_W +: GRP_W]),
        .o_g  (w_g[i]),
        .o_p  (w_p[i])
      );
    end
    // Each group carry is a flat sum of products over the stage's G/P, no ripple.
    always_comb begin
      logic cc, pp;
      w_c[0] = w_ci;
      for (int i = 0; i < GPS; i++) begin
        cc = w_g[i];
        pp = w_p[i];
        for (int j = i - 1; j >= 0; j--) begin
          cc = cc | (pp & w_g[j]);
          pp = pp & w_p[j];
        end
        w_c[i+1] = cc | (pp & w_ci);
      end
    end
    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:HI] r_a, r_b;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a[WIDTH-1:HI];
          r_b <= w_b[WIDTH-1:HI];
        end
      assign w_s_nx = w_s;
    end else begin : g_out
      logic w_ovf, r_ovf;
      // carry into MSB is a^b^s at the MSB; overflow when it differs from carry out
      assign w_ovf = w_a[WIDTH-1] ^ w_b[WIDTH-1] ^ w_s[WIDTH-1] ^ w_c[GPS];
`ifdef ADD_PIPE_SAT_EN
      assign w_s_nx = w_ovf ? {w_a[WIDTH-1], {(WIDTH-1){~w_a[WIDTH-1]}}} : w_s;
`else
      assign w_s_nx = w_s;
`endif
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_ovf <= 1'b0;
        else if (w_adv) r_ovf <= w_ovf;
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_s <= '0;
        r_c <= 1'b0;
        r_v <= 1'b0;
      end else if (w_adv) begin
        r_s <= w_s_nx;
        r_c <= w_c[GPS];
        r_v <= w_vi;
      end
  end
  assign w_adv = !g_st[STAGES-1].r_v | out_ready;
  assign in_ready = w_adv;
  assign out_valid = g_st[STAGES-1].r_v;
  assign sum = g_st[STAGES-1].r_s;
  assign cout = g_st[STAGES-1].r_c;
  assign ovf = g_st[STAGES-1].g_out.r_ovf;
endmodule
